md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Lives in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the forwarded rs/rt operands of the EX-stage instruction.
- Produces busy for the hazard unit, which stalls ID on mult/div/mfhi/mflo/mthi/mtlo while busy or start is high.
- Produces HI/LO for the mfhi/mflo result mux.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.
- CNT_W, 4: counter width; must satisfy 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  EX instruction is a valid mult/multu/div/divu/mthi/mtlo; low for bubbles and flushed slots.
- md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved.
- a  in  32  forwarded rs value.
- b  in  32  forwarded rt value.
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: on the edge with reset=1, hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset overrides start, and aborts any operation in flight with no HI/LO update.
- Accept: start=1 and busy=0 at edge T.
  - mult/multu: full 64-bit product of a and b (signed for mult, unsigned for multu) captured into the pending {phi,plo}; counter<=MULT_CYCLES.
  - div/divu: quotient to plo, remainder to phi; counter<=DIV_CYCLES.
  - mthi: hi<=a at edge T, no busy. mtlo: lo<=a at edge T, no busy.
  - Reserved md_op: ignored, no state change.
- Operands are sampled only at edge T. Later changes to a/b do not affect the result.
- Busy timing:
  - busy = (counter != 0), registered.
  - busy is high for exactly N cycles after edge T (N = MULT_CYCLES or DIV_CYCLES).
  - Counter decrements each edge while nonzero.
  - On the edge where counter goes 1->0: hi<=phi, lo<=plo, busy falls.
  - New HI/LO is visible in the first cycle with busy=0.
- start while busy=1: ignored. The hazard unit guarantees this never happens; the unit must still not corrupt state.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- Divide by zero (b=0, div or divu): busy runs the full DIV_CYCLES, then HI/LO keep their prior values (no load).
- Width: the product is computed as 64-bit with operands sign- or zero-extended per op. No truncation before the HI/LO split.
- HI/LO are not written by any other path. The mfhi/mflo read is combinational from the hi/lo outputs.

Decomposition:
- Shared package, used by the controller and the hazard unit:
  - MD_MULT=3'b000, MD_MULTU=3'b001, MD_DIV=3'b010, MD_DIVU=3'b011, MD_MTHI=3'b100, MD_MTLO=3'b101.
  - Default cycle-count constants.
- No sub-module. Keep a single module: counter, pending registers and HI/LO in one sequential block, plus one combinational compute block.

Test Plan:
- reset=1 for 2 cycles, then start=1, md_op=MULT, a=0xFFFFFFFF, b=2 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE with busy=0 in the same cycle.
- MULTU, a=0xFFFFFFFF, b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=7, b=0 with prior hi=0x11, lo=0x22 -> 10 busy cycles; HI/LO stay 0x11/0x22.
- MTHI, a=0x12345678, then MTLO, a=0xCAFEBABE on consecutive edges -> busy never asserts; hi=0x12345678 after the 1st edge, lo=0xCAFEBABE after the 2nd.
- MULT start, change a/b and pulse start=1 with DIV on cycles 2-3 -> second start ignored; result equals the original product; busy length stays 5.
- DIV start, reset=1 on cycle 4 -> next cycle busy=0, hi=lo=0; no late HI/LO update on later edges.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared multiply/divide opcode encodings and default latencies.
// Imported by the MD controller and the hazard unit.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/md_unit.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at acceptance, held pending, and committed when the countdown expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             pload_q, pload_d;
  logic             busy_q, busy_d;

  logic        smul_s, sdiv_s;
  logic [63:0] ext_a_s, ext_b_s, prod_s;
  logic [31:0] mag_a_s, mag_b_s, divisor_s, uq_s, ur_s, q_s, r_s;

  // Datapath and next-state: products/quotients are formed at acceptance only.
  always_comb begin
    smul_s  = (md_op == MD_MULT);
    sdiv_s  = (md_op == MD_DIV);
    ext_a_s = {{32{a[31] & smul_s}}, a};
    ext_b_s = {{32{b[31] & smul_s}}, b};
    prod_s  = ext_a_s * ext_b_s;

    // Signed divide via magnitudes keeps 0x80000000 / -1 well defined.
    mag_a_s   = (sdiv_s && a[31]) ? (32'd0 - a) : a;
    mag_b_s   = (sdiv_s && b[31]) ? (32'd0 - b) : b;
    divisor_s = (b == 32'd0) ? 32'd1 : mag_b_s;
    uq_s      = mag_a_s / divisor_s;
    ur_s      = mag_a_s % divisor_s;
    q_s       = (sdiv_s && (a[31] ^ b[31])) ? (32'd0 - uq_s) : uq_s;
    r_s       = (sdiv_s && a[31]) ? (32'd0 - ur_s) : ur_s;

    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pload_d = pload_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1} && pload_q) begin
        hi_d    = phi_q;
        lo_d    = plo_q;
        pload_d = 1'b0;
      end else begin
        pload_d = pload_q;
      end
    end else if (start) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          phi_d   = prod_s[63:32];
          plo_d   = prod_s[31:0];
          pload_d = 1'b1;
          cnt_d   = CNT_W'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          phi_d   = r_s;
          plo_d   = q_s;
          pload_d = (b != 32'd0);
          cnt_d   = CNT_W'(DIV_CYCLES);
        end
        MD_MTHI: hi_d = a;
        MD_MTLO: lo_d = a;
        default: cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end

    busy_d = (cnt_d != {CNT_W{1'b0}});
  end

  // State register: countdown, pending result, HI/LO and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= {CNT_W{1'b0}};
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pload_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pload_q <= pload_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
